snail_detect_sched: RTL and testbench

- Shares one "101" overlapping Moore sequence detector among NREQ requesters.
- Each requester offers a WIDTH-bit word. A round-robin arbiter grants one requester. The block serializes the granted word MSB-first through the detector and reports the match count with a done pulse.
- Sits in front of the bit-serial "101" snail detector path and turns it into a word-level, multi-client service.

---
 rtl/snail_detect_sched.sv | 194 +++++++++++++++++++
 tb/tb_snail_detect_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snail_detect_sched.sv
`default_nettype none
// ============================================================================
//  Module      : snail_detect_sched
//  Description : Round-robin scheduler that shares one overlapping "101"
//                Moore sequence detector among NREQ requesters. The granted
//                word is serialized MSB-first through the detector, and the
//                match count is reported with a one-cycle done pulse.
//                Optional build macro SNAIL_SCHED_STATS_EN adds the
//                total_matches / jobs_done statistics outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module snail_detect_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  ser_bit,
  output logic                  ser_valid,
  output logic                  det_q,
  output logic                  done,
  output logic [ID_W-1:0]       done_id,
  output logic [CNT_W-1:0]      match_cnt
`ifdef SNAIL_SCHED_STATS_EN
  ,
  output logic [15:0]           total_matches,
  output logic [15:0]           jobs_done
`endif
);

  // Bit counter runs 0..WIDTH-1 over the SHIFT phase.
  localparam int BC_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    S0   = 2'd0,
    S1   = 2'd1,
    S10  = 2'd2,
    S101 = 2'd3
  } det_t;

  state_t           r_state;
  state_t           w_state_n;
  det_t             r_det;
  det_t             w_det_n;
  logic [ID_W-1:0]  r_ptr;
  logic [BC_W-1:0]  r_bitcnt;
  logic [WIDTH-1:0] r_sh;

  logic             w_found;
  logic [ID_W-1:0]  w_win;
  logic [ID_W-1:0]  w_idx;
  logic [WIDTH-1:0] w_word;
  logic             w_last_bit;

  // Round-robin pick: first asserted request scanning upward from the pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = ID_W'((int'(r_ptr) + i) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_word     = data[int'(w_win)*WIDTH +: WIDTH];
  assign w_last_bit = (r_bitcnt == BC_W'(WIDTH - 1));

  // Detector transition on the bit currently presented (overlapping "101").
  always_comb begin
    w_det_n = S0;
    case (r_det)
      S0:      w_det_n = ser_bit ? S1   : S0;
      S1:      w_det_n = ser_bit ? S1   : S10;
      S10:     w_det_n = ser_bit ? S101 : S0;
      default: w_det_n = ser_bit ? S1   : S10;
    endcase
  end

  // Scheduler state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  // Scheduler next-state: IDLE -> SHIFT on any request, WIDTH bits, one REPORT cycle.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_n = SHIFT;
      SHIFT:   if (w_last_bit) w_state_n = REPORT;
      REPORT:  w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // Datapath and registered outputs: grant/latch, serialize, count, report.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= '0;
      busy      <= 1'b0;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      det_q     <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
      r_ptr     <= '0;
      r_det     <= S0;
      r_bitcnt  <= '0;
      r_sh      <= '0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      busy <= (w_state_n != IDLE);
      case (r_state)
        IDLE: begin
          if (w_found) begin
            // First bit goes out with the grant; the rest waits in r_sh.
            ser_bit   <= w_word[WIDTH-1];
            ser_valid <= 1'b1;
            r_sh      <= w_word << 1;
            gnt       <= NREQ'(1) << w_win;
            r_ptr     <= ID_W'((int'(w_win) + 1) % NREQ);
            done_id   <= w_win;
            r_bitcnt  <= '0;
            match_cnt <= '0;
            r_det     <= S0;
            det_q     <= 1'b0;
          end
        end
        SHIFT: begin
          r_det    <= w_det_n;
          det_q    <= (w_det_n == S101);
          r_bitcnt <= r_bitcnt + BC_W'(1);
          if (w_det_n == S101) match_cnt <= match_cnt + CNT_W'(1);
          if (w_last_bit) begin
            ser_valid <= 1'b0;
            ser_bit   <= 1'b0;
            done      <= 1'b1;
          end else begin
            ser_bit <= r_sh[WIDTH-1];
            r_sh    <= r_sh << 1;
          end
        end
        REPORT: begin
          // Detector restarts per word, so det_q only lasts into REPORT.
          r_det <= S0;
          det_q <= 1'b0;
        end
        default: begin
          r_det <= S0;
          det_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SNAIL_SCHED_STATS_EN
  logic [16:0] w_sum_matches;
  logic [16:0] w_sum_jobs;

  assign w_sum_matches = {1'b0, total_matches} + 17'(match_cnt);
  assign w_sum_jobs    = {1'b0, jobs_done} + 17'd1;

  // Saturating job statistics, accumulated as each REPORT cycle closes.
  always_ff @(posedge clk) begin
    if (rst) begin
      total_matches <= '0;
      jobs_done     <= '0;
    end else if (r_state == REPORT) begin
      total_matches <= w_sum_matches[16] ? 16'hFFFF : w_sum_matches[15:0];
      jobs_done     <= w_sum_jobs[16]    ? 16'hFFFF : w_sum_jobs[15:0];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_snail_detect_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snail_detect_sched
//  Description : Self-checking bench for snail_detect_sched with a
//                word-level reference model (window pattern count,
//                round-robin pick over a request mask).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snail_detect_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] data = '0;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  ser_bit;
  logic                  ser_valid;
  logic                  det_q;
  logic                  done;
  logic [ID_W-1:0]       done_id;
  logic [CNT_W-1:0]      match_cnt;
`ifdef SNAIL_SCHED_STATS_EN
  logic [15:0]           total_matches;
  logic [15:0]           jobs_done;
`endif

  int  checks   = 0;
  int  failures = 0;
  int  m_ptr    = 0;
  time last_done_t = 0;

  snail_detect_sched #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .CNT_W(CNT_W),
    .ID_W (ID_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .data         (data),
    .gnt          (gnt),
    .busy         (busy),
    .ser_bit      (ser_bit),
    .ser_valid    (ser_valid),
    .det_q        (det_q),
    .done         (done),
    .done_id      (done_id),
`ifdef SNAIL_SCHED_STATS_EN
    .total_matches(total_matches),
    .jobs_done    (jobs_done),
`endif
    .match_cnt    (match_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample/drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic bitpos(input logic [WIDTH-1:0] w, input int p);
    logic [WIDTH-1:0] t;
    t = w;
    return t[WIDTH-1-p];
  endfunction

  // Overlapping "101" occurrences in the MSB-first bit string.
  function automatic int model_count(input logic [WIDTH-1:0] w);
    int n;
    n = 0;
    for (int p = 0; p + 2 < WIDTH; p++)
      if (bitpos(w, p) && !bitpos(w, p + 1) && bitpos(w, p + 2)) n++;
    return n;
  endfunction

  // det_q in cycle m after the grant edge: last three bits seen end in "101".
  function automatic logic model_det(input logic [WIDTH-1:0] w, input int m);
    if (m < 4) return 1'b0;
    return bitpos(w, m - 4) && !bitpos(w, m - 3) && bitpos(w, m - 2);
  endfunction

  function automatic int model_pick(input logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++) begin
      int c;
      c = (m_ptr + i) % NREQ;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NREQ*WIDTH-1:0] rand_data();
    logic [NREQ*WIDTH-1:0] d;
    for (int i = 0; i < NREQ; i++) d[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
    return d;
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    m_ptr = 0;
  endtask

  // Follows one job from the arbitration edge through REPORT and the IDLE gap.
  task automatic observe_job(input int exp_id, input logic [WIDTH-1:0] word,
                             input bit release_req, input string tag);
    logic [NREQ+4:0]            o_s, e_s;
    logic [NREQ+3+ID_W+CNT_W:0] o_r, e_r;
    logic [NREQ-1:0]            g1;
    logic [NREQ-1:0]            e_g;
    g1 = NREQ'(1) << exp_id;
    m_ptr = (exp_id + 1) % NREQ;
    for (int m = 1; m <= WIDTH; m++) begin
      tick();
      if (m == 1) begin
        if (release_req) req = '0;
        data = rand_data();
      end
      e_g = (m == 1) ? g1 : NREQ'(0);
      o_s = {gnt, busy, ser_valid, ser_bit, done, det_q};
      e_s = {e_g, 1'b1, 1'b1, bitpos(word, m - 1), 1'b0, model_det(word, m)};
      checks++;
      if (o_s !== e_s) begin
        failures++;
        $display("FAIL %s shift cycle %0d {gnt,busy,sv,sb,done,det}: got %b want %b", tag, m, o_s, e_s);
      end
    end
    tick();
    o_r = {gnt, busy, ser_valid, done, det_q, done_id, match_cnt};
    e_r = {NREQ'(0), 1'b1, 1'b0, 1'b1, model_det(word, WIDTH + 1), ID_W'(exp_id), CNT_W'(model_count(word))};
    checks++;
    if (o_r !== e_r) begin
      failures++;
      $display("FAIL %s report {gnt,busy,sv,done,det,id,cnt}: got %b want %b", tag, o_r, e_r);
    end
    last_done_t = $time;
    tick();
    checks++;
    if ({gnt, busy, done, ser_valid, det_q} !== '0) begin
      failures++;
      $display("FAIL %s idle gap {gnt,busy,done,sv,det}: got %b want 0", tag, {gnt, busy, done, ser_valid, det_q});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    data = rand_data();
    tick();
    tick();
    checks++;
    if ({gnt, busy, ser_bit, ser_valid, det_q, done, done_id, match_cnt} !== '0) begin
      failures++;
      $display("FAIL reset outputs: got %b want 0", {gnt, busy, ser_bit, ser_valid, det_q, done, done_id, match_cnt});
    end
    rst = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({gnt, busy, done, ser_valid} !== '0) begin
      failures++;
      $display("FAIL idle no request: got %b want 0", {gnt, busy, done, ser_valid});
    end
  endtask

  task automatic test_plan_word();
    logic [WIDTH-1:0] w;
    int e;
    w = 8'b1010_1101;
    data = rand_data();
    data[WIDTH-1:0] = w;
    req = 4'b0001;
    e = model_pick(req);
    observe_job(e, w, 1'b1, "plan_word");
  endtask

  task automatic test_single_words();
    logic [WIDTH-1:0] words [4];
    int r, e;
    words = '{8'hFF, 8'hAA, 8'h55, 8'h45};
    for (int k = 0; k < 4; k++) begin
      r = int'($urandom_range(0, NREQ - 1));
      data = rand_data();
      data[r*WIDTH +: WIDTH] = words[k];
      req = NREQ'(1) << r;
      e = model_pick(req);
      observe_job(e, words[k], 1'b1, "single_word");
    end
  endtask

  task automatic test_back_to_back();
    logic [NREQ*WIDTH-1:0] d;
    int e;
    time prev_t;
    reset_dut();
    d = rand_data();
    req = 4'b1111;
    prev_t = 0;
    for (int j = 0; j < 5; j++) begin
      data = d;
      e = model_pick(req);
      observe_job(e, d[e*WIDTH +: WIDTH], 1'b0, "back_to_back");
      if (j > 0) begin
        checks++;
        if (last_done_t - prev_t != 100) begin
          failures++;
          $display("FAIL done spacing: got %0t want 100", last_done_t - prev_t);
        end
      end
      prev_t = last_done_t;
    end
    req = '0;
  endtask

  task automatic test_pointer();
    logic [NREQ*WIDTH-1:0] d;
    int e;
    reset_dut();
    d = rand_data();
    req = 4'b0101;
    for (int j = 0; j < 4; j++) begin
      data = d;
      e = model_pick(req);
      observe_job(e, d[e*WIDTH +: WIDTH], 1'b0, "ptr_0101");
    end
    data = d;
    req = 4'b1000;
    e = model_pick(req);
    observe_job(e, d[e*WIDTH +: WIDTH], 1'b1, "ptr_wrap_3");
    data = d;
    req = 4'b1001;
    e = model_pick(req);
    observe_job(e, d[e*WIDTH +: WIDTH], 1'b1, "ptr_wrap_0");
  endtask

  task automatic test_reset_midjob();
    int bad;
    int e;
    reset_dut();
    data = rand_data();
    req = 4'b0100;
    e = model_pick(req);
    m_ptr = (e + 1) % NREQ;
    for (int i = 0; i < 4; i++) begin
      tick();
      req = '0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ptr = 0;
    checks++;
    if ({gnt, busy, ser_bit, ser_valid, det_q, done, done_id, match_cnt} !== '0) begin
      failures++;
      $display("FAIL midjob reset outputs: got %b want 0", {gnt, busy, ser_bit, ser_valid, det_q, done, done_id, match_cnt});
    end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL aborted job activity: got %0d active cycles want 0", bad);
    end
    data = {NREQ{8'hAA}};
    req = 4'b1111;
    e = model_pick(req);
    observe_job(e, 8'hAA, 1'b1, "after_reset");
  endtask

  task automatic test_random();
    logic [NREQ*WIDTH-1:0] d;
    int e;
    for (int j = 0; j < 20; j++) begin
      d = rand_data();
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      data = d;
      e = model_pick(req);
      observe_job(e, d[e*WIDTH +: WIDTH], 1'($urandom_range(0, 1)), "random");
    end
    req = '0;
  endtask

`ifdef SNAIL_SCHED_STATS_EN
  task automatic test_stats();
    logic [WIDTH-1:0] words [3];
    int e, tot;
    words = '{8'hAA, 8'h45, 8'hFF};
    reset_dut();
    tot = 0;
    for (int k = 0; k < 3; k++) begin
      data = rand_data();
      data[WIDTH +: WIDTH] = words[k];
      req = 4'b0010;
      e = model_pick(req);
      observe_job(e, words[k], 1'b1, "stats_job");
      tot += model_count(words[k]);
    end
    checks++;
    if (total_matches !== 16'(tot) || jobs_done !== 16'd3) begin
      failures++;
      $display("FAIL stats totals: got %0d/%0d want %0d/3", total_matches, jobs_done, tot);
    end
    reset_dut();
    checks++;
    if (total_matches !== 16'd0 || jobs_done !== 16'd0) begin
      failures++;
      $display("FAIL stats reset: got %0d/%0d want 0/0", total_matches, jobs_done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_plan_word();
    test_single_words();
    test_back_to_back();
    test_pointer();
    test_reset_midjob();
    test_random();
`ifdef SNAIL_SCHED_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
